// File: rtl/control_alineacion_serial.sv
// Word-alignment controller: hunts the K28.5 comma in a serial bit stream,
// locks the 10-bit word boundary and emits aligned words with a valid strobe.
module control_alineacion_serial #(
    parameter int unsigned cantidadBits = 10,
    parameter logic [cantidadBits-1:0] COMA_POS = 10'b0011111010,
    parameter logic [cantidadBits-1:0] COMA_NEG = 10'b1100000101,
    parameter int unsigned COMAS_SYNC = 3,
    parameter int unsigned ERRORES_MAX = 4,
    parameter int unsigned MAX_SIN_COMA = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enb,
    input  logic                    entrada,
    output logic [cantidadBits-1:0] salidas,
    output logic                    valido,
    output logic                    sincronizado,
    output logic [1:0]              estado
);

    localparam int unsigned CW = $clog2(cantidadBits);
    localparam logic [CW-1:0] CNT_MAX = CW'(cantidadBits - 1);
    localparam logic [2:0] SYNC_OBJ = 3'(COMAS_SYNC);
    localparam logic [2:0] ERR_OBJ = 3'(ERRORES_MAX);
    localparam logic [7:0] SIN_OBJ = 8'(MAX_SIN_COMA);

    typedef enum logic [1:0] {
        BUSCANDO     = 2'b00,
        VERIFICANDO  = 2'b01,
        SINCRONIZADO = 2'b10
    } estado_t;

    estado_t                 estado_q, estado_d;
    logic [cantidadBits-1:0] ventana_q, ventana_d;
    logic [cantidadBits-1:0] salidas_q, salidas_d;
    logic                    valido_q, valido_d;
    logic [CW-1:0]           contador_q, contador_d;
    logic [2:0]              cuenta_q, cuenta_d;
    logic [2:0]              errores_q, errores_d;
    logic [7:0]              sin_coma_q, sin_coma_d;

    logic [cantidadBits-1:0] ventana_n;
    logic                    coma;
    logic                    frontera;
    logic [2:0]              cuenta_inc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            estado_q   <= BUSCANDO;
            ventana_q  <= '0;
            salidas_q  <= '0;
            valido_q   <= 1'b0;
            contador_q <= '0;
            cuenta_q   <= '0;
            errores_q  <= '0;
            sin_coma_q <= '0;
        end else begin
            estado_q   <= estado_d;
            ventana_q  <= ventana_d;
            salidas_q  <= salidas_d;
            valido_q   <= valido_d;
            contador_q <= contador_d;
            cuenta_q   <= cuenta_d;
            errores_q  <= errores_d;
            sin_coma_q <= sin_coma_d;
        end
    end

    always_comb begin
        estado_d   = estado_q;
        ventana_d  = ventana_q;
        salidas_d  = salidas_q;
        valido_d   = 1'b0;
        contador_d = contador_q;
        cuenta_d   = cuenta_q;
        errores_d  = errores_q;
        sin_coma_d = sin_coma_q;

        ventana_n  = {ventana_q[cantidadBits-2:0], entrada};
        coma       = (ventana_n == COMA_POS) || (ventana_n == COMA_NEG);
        frontera   = (contador_q == CNT_MAX);
        cuenta_inc = cuenta_q + 3'd1;

        if (enb) begin
            ventana_d  = ventana_n;
            contador_d = frontera ? '0 : contador_q + 1'b1;
            unique case (estado_q)
                BUSCANDO: begin
                    if (coma) begin
                        contador_d = '0;
                        cuenta_d   = 3'd1;
                        estado_d   = VERIFICANDO;
                    end
                end
                VERIFICANDO: begin
                    if (frontera && coma) begin
                        cuenta_d = cuenta_inc;
                        if (cuenta_inc >= SYNC_OBJ) begin
                            estado_d   = SINCRONIZADO;
                            salidas_d  = ventana_n;
                            valido_d   = 1'b1;
                            errores_d  = '0;
                            sin_coma_d = '0;
                        end
                    end else if (frontera) begin
                        estado_d = BUSCANDO;
                        cuenta_d = '0;
                    end else if (coma) begin
                        // a comma off the expected boundary re-anchors the hunt
                        contador_d = '0;
                        cuenta_d   = 3'd1;
                    end
                end
                SINCRONIZADO: begin
                    if (frontera) begin
                        salidas_d = ventana_n;
                        valido_d  = 1'b1;
                        if (coma) begin
                            errores_d  = '0;
                            sin_coma_d = '0;
                        end else if (sin_coma_q != 8'hFF) begin
                            sin_coma_d = sin_coma_q + 8'd1;
                        end
                    end else if (coma && errores_q != 3'd7) begin
                        errores_d = errores_q + 3'd1;
                    end
                    if (errores_d >= ERR_OBJ || sin_coma_d >= SIN_OBJ) begin
                        estado_d   = BUSCANDO;
                        contador_d = '0;
                        cuenta_d   = '0;
                        errores_d  = '0;
                        sin_coma_d = '0;
                    end
                end
                default: begin
                    estado_d   = BUSCANDO;
                    contador_d = '0;
                    cuenta_d   = '0;
                end
            endcase
        end
    end

    assign salidas      = salidas_q;
    assign valido       = valido_q;
    assign estado       = estado_q;
    assign sincronizado = (estado_q == SINCRONIZADO);

endmodule

// File: tb/tb_control_alineacion_serial.sv
// Bench for control_alineacion_serial: directed scenarios plus randomized
// streams, compared against a bit-history reference model.
module tb_control_alineacion_serial;

    localparam logic [9:0] COMA_POS = 10'b0011111010;
    localparam logic [9:0] COMA_NEG = 10'b1100000101;
    localparam int COMAS_SYNC = 3;
    localparam int ERRORES_MAX = 4;
    localparam int MAX_SIN_COMA = 255;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       enb = 1'b0;
    logic       entrada = 1'b0;
    logic [9:0] salidas;
    logic       valido;
    logic       sincronizado;
    logic [1:0] estado;

    int checks = 0;
    int errors = 0;

    control_alineacion_serial dut (
        .clk(clk),
        .rst(rst),
        .enb(enb),
        .entrada(entrada),
        .salidas(salidas),
        .valido(valido),
        .sincronizado(sincronizado),
        .estado(estado)
    );

    always #5 clk = ~clk;

    // reference model: sampled-bit history and an anchor sample index
    bit         hist[$];
    int         n_mod;
    int         ancla;
    int         m_est;
    int         m_comas;
    int         m_err;
    int         m_sin;
    logic [9:0] exp_sal;
    logic       exp_val;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic modelo_reset();
        hist.delete();
        n_mod = 0; ancla = 0; m_est = 0;
        m_comas = 0; m_err = 0; m_sin = 0;
        exp_sal = '0; exp_val = 1'b0;
    endtask

    task automatic modelo_paso(input logic e, input logic b);
        logic [9:0] w;
        logic       c;
        logic       borde;
        exp_val = 1'b0;
        if (!e) return;
        hist.push_back(b);
        if (hist.size() > 10) void'(hist.pop_front());
        n_mod++;
        w = '0;
        foreach (hist[i]) w = {w[8:0], hist[i]};
        c = (w == COMA_POS) || (w == COMA_NEG);
        borde = (n_mod > ancla) && ((n_mod - ancla) % 10 == 0);
        if (m_est == 0) begin
            if (c) begin ancla = n_mod; m_comas = 1; m_est = 1; end
        end else if (m_est == 1) begin
            if (borde && c) begin
                m_comas++;
                if (m_comas >= COMAS_SYNC) begin
                    m_est = 2; exp_sal = w; exp_val = 1'b1;
                    m_err = 0; m_sin = 0;
                end
            end else if (borde) begin
                m_est = 0; m_comas = 0;
            end else if (c) begin
                ancla = n_mod; m_comas = 1;
            end
        end else begin
            if (borde) begin
                exp_sal = w; exp_val = 1'b1;
                if (c) begin m_err = 0; m_sin = 0; end
                else m_sin++;
            end else if (c) begin
                m_err++;
            end
            if (m_err >= ERRORES_MAX || m_sin >= MAX_SIN_COMA) begin
                m_est = 0; m_err = 0; m_sin = 0; m_comas = 0;
            end
        end
    endtask

    task automatic verificar();
        chk("estado", 32'(estado), 32'(m_est));
        chk("sincronizado", 32'(sincronizado), 32'(m_est == 2));
        chk("salidas", 32'(salidas), 32'(exp_sal));
        chk("valido", 32'(valido), 32'(exp_val));
    endtask

    // one clock: inputs applied at negedge, checked at the next negedge
    task automatic ciclo(input logic e, input logic b);
        enb = e; entrada = b;
        @(posedge clk);
        modelo_paso(e, b);
        @(negedge clk);
        verificar();
    endtask

    task automatic enviar(input logic [9:0] w, input logic gap);
        for (int i = 9; i >= 0; i--) begin
            ciclo(1'b1, w[i]);
            if (gap) ciclo(1'b0, 1'($urandom));
        end
    endtask

    task automatic reiniciar();
        @(negedge clk);
        rst = 1'b0; enb = 1'b0; entrada = 1'b0;
        modelo_reset();
        #1;
        chk("rst_estado", 32'(estado), 32'd0);
        chk("rst_salidas", 32'(salidas), 32'd0);
        chk("rst_valido", 32'(valido), 32'd0);
        chk("rst_sinc", 32'(sincronizado), 32'd0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        logic [29:0] pat;
        logic [9:0]  w;
        int          nval;
        pat = {COMA_POS, COMA_POS, COMA_POS};
        modelo_reset();

        // 1: three aligned commas lock at bit 30
        reiniciar();
        for (int b = 0; b < 30; b++) begin
            ciclo(1'b1, pat[29-b]);
            if (b == 8) chk("t1_estado_b9", 32'(estado), 32'd0);
            if (b == 9) chk("t1_estado_b10", 32'(estado), 32'd1);
            if (b == 28) chk("t1_sinc_b29", 32'(sincronizado), 32'd0);
        end
        chk("t1_sinc", 32'(sincronizado), 32'd1);
        chk("t1_valido", 32'(valido), 32'd1);
        chk("t1_salidas", 32'(salidas), 32'h0FA);

        // 2: data words while locked
        enviar(10'h155, 1'b0);
        chk("t2_sal155", 32'(salidas), 32'h155);
        chk("t2_val155", 32'(valido), 32'd1);
        enviar(10'h2AA, 1'b0);
        chk("t2_sal2AA", 32'(salidas), 32'h2AA);
        chk("t2_sinc", 32'(sincronizado), 32'd1);

        // 3: four commas off the boundary by 3 bits drop the lock
        enviar(COMA_POS, 1'b0);
        for (int i = 0; i < 3; i++) ciclo(1'b1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            enviar(COMA_NEG, 1'b0);
            if (k == 2) chk("t3_sinc_3err", 32'(sincronizado), 32'd1);
        end
        chk("t3_estado", 32'(estado), 32'd0);
        chk("t3_sinc", 32'(sincronizado), 32'd0);

        // 4: one comma then a non-comma boundary word
        reiniciar();
        enviar(COMA_POS, 1'b0);
        chk("t4_verif", 32'(estado), 32'd1);
        nval = 0;
        w = 10'h155;
        for (int i = 9; i >= 0; i--) begin
            ciclo(1'b1, w[i]);
            if (valido) nval++;
        end
        chk("t4_estado", 32'(estado), 32'd0);
        chk("t4_sin_valido", 32'(nval), 32'd0);

        // 5: enb toggling every cycle
        reiniciar();
        for (int b = 0; b < 30; b++) begin
            ciclo(1'b1, pat[29-b]);
            if (b == 9) chk("t5_estado_e10", 32'(estado), 32'd1);
            if (b == 29) begin
                chk("t5_sinc", 32'(sincronizado), 32'd1);
                chk("t5_salidas", 32'(salidas), 32'h0FA);
            end
            ciclo(1'b0, 1'($urandom));
            chk("t5_valido_enb0", 32'(valido), 32'd0);
        end

        // 6: asynchronous reset mid-word while locked
        for (int i = 0; i < 4; i++) ciclo(1'b1, 1'($urandom));
        #2 rst = 1'b0;
        #1;
        chk("t6_estado", 32'(estado), 32'd0);
        chk("t6_salidas", 32'(salidas), 32'd0);
        chk("t6_sinc", 32'(sincronizado), 32'd0);
        chk("t6_valido", 32'(valido), 32'd0);
        modelo_reset();
        @(negedge clk);
        rst = 1'b1;
        enviar(COMA_POS, 1'b0);
        enviar(COMA_POS, 1'b0);
        chk("t6_sin_lock2", 32'(sincronizado), 32'd0);
        enviar(COMA_POS, 1'b0);
        chk("t6_relock", 32'(sincronizado), 32'd1);

        // 7: MAX_SIN_COMA words without a boundary comma
        for (int k = 0; k < MAX_SIN_COMA - 1; k++) enviar(10'h155, 1'b0);
        chk("t7_sinc_254", 32'(sincronizado), 32'd1);
        enviar(10'h155, 1'b0);
        chk("t7_estado_255", 32'(estado), 32'd0);
        chk("t7_valido_255", 32'(valido), 32'd1);
        chk("t7_salidas_255", 32'(salidas), 32'h155);

        // 8: randomized streams with slips and enb gaps
        reiniciar();
        for (int k = 0; k < 400; k++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 4) w = COMA_POS;
            else if (r < 6) w = COMA_NEG;
            else w = 10'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                int s;
                s = $urandom_range(1, 3);
                for (int i = 0; i < s; i++) ciclo(1'b1, 1'($urandom));
            end
            for (int i = 9; i >= 0; i--) begin
                if ($urandom_range(0, 4) == 0) ciclo(1'b0, 1'($urandom));
                ciclo(1'b1, w[i]);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
